// File: rtl/lsu_align.sv
// lsu_align: RV32 load/store aligner that performs sub-word stores as
// read-modify-write over a whole-word-only memory port.
module lsu_align #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_type,
  input  logic [MEM_AW+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_type,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t            state;
  logic              is_store_q;
  logic [2:0]        type_q;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              legal, misaligned, err, is_sw;
  logic [4:0]        sh;
  logic [31:0]       lane, load_data, mask, merged;
  assign legal      = req_is_store ? (req_type <= 3'd2) : !(req_type inside {3'd3, 3'd6, 3'd7});
  assign misaligned = (req_type[1:0] == 2'b01 && req_addr[0]) || (req_type[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign err        = !legal || misaligned;
  assign is_sw      = req_is_store && req_type == 3'd2;
  // Lane selection shifts the addressed byte/half down to bit 0; aligned accesses keep it exact.
  assign sh        = {addr_q[1:0], 3'b000};
  assign lane      = mem_rdata >> sh;
  assign load_data = type_q[1] ? lane :
                     type_q[0] ? {{16{~type_q[2] & lane[15]}}, lane[15:0]} :
                                 {{24{~type_q[2] & lane[7]}}, lane[7:0]};
  assign mask      = (type_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
  assign merged    = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_addr   = addr_q[MEM_AW+1:2];
  assign mem_type   = 3'b010;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      type_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          type_q     <= req_type;
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= err;
          mem_wdata  <= req_wdata;
          mem_we     <= !err && is_sw;
          state      <= err ? RESP : is_sw ? WRITE : READ;
        end
        READ: begin
          mem_wdata  <= is_store_q ? merged : mem_wdata;
          mem_we     <= is_store_q;
          resp_rdata <= is_store_q ? resp_rdata : load_data;
          state      <= is_store_q ? WRITE : RESP;
        end
        WRITE: begin
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: state <= resp_ready ? IDLE : RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
